alu_seq: RTL
============

# alu_seq

Parametrised, multi-cycle successor to the 8-bit accumulator ALU.
- Keeps the existing 4-bit opcode map and operand roles (R0 = accumulator, Input = register/immediate operand), generalised to WIDTH bits.
- Adds multi-cycle operations: barrel-free shift-by-N and shift-add multiply.
- Uses a Start/Busy/Done handshake and registers all results.
- Sits between the decoder/register file and the writeback mux of the accumulator datapath.

## Interface
Parameters
- WIDTH, default 8: datapath width; must be ≥ 2 and a power of two.
- SHW, default $clog2(WIDTH): shift-amount width, derived; do not override.

Ports
- CLK, in, 1: single clock, rising edge.
- Reset_n, in, 1: asynchronous, active-low reset.
- Start, in, 1: request; operands and OP are sampled on the CLK edge where Start=1 and Busy=0.
- OP, in, 4: opcode.
- Mode, in, 1: selects shift-by-N for OP 7/8.
- R0, in, WIDTH: accumulator operand.
- Input, in, WIDTH: second operand.
- Busy, out, 1: operation in progress.
- Done, out, 1: one-cycle pulse; results valid.
- Out, out, WIDTH: result (MUL low half).
- Hi, out, WIDTH: MUL high half; 0 for all other ops.
- Zero, out, 1: Out == 0.
- C_out, out, 1: carry/flag, see Operation.

## Operation
Opcodes (A = latched R0, B = latched Input)
- 0, 1, 5, 6: Out = B.
- 2: {C_out, Out} = A + B.
- 3: Out = A − B; C_out = borrow (A < B unsigned).
- 4: Out = A.
- 7 (Mode=0): Out = B << 1; C_out = B[WIDTH−1].
- 8 (Mode=0): Out = B >> 1; C_out = B[0].
- 7/8 (Mode=1): shift B by n = A[SHW−1:0], one bit per cycle; C_out = last bit shifted out, 0 if n = 0.
- 9: A & B. 10: A ^ B.
- 11/12/13: Out = 1 if A == B / A < B / A > B (unsigned), else 0.
- 14 (MUL): {Hi, Out} = A × B unsigned, shift-add, one partial product per cycle; C_out = |Hi.
- 15: Out = B if A == 0, else 0.
- C_out = 0 wherever not listed above.

State machine: IDLE, SHIFT, MUL, DONE.
- IDLE + accepted Start:
  - single-cycle op → DONE, result registered.
  - shift-by-N with n > 0 → SHIFT, count = n.
  - MUL → MUL, count = WIDTH.
- SHIFT / MUL: decrement count each cycle; at count = 1 → DONE.
- DONE: Done = 1 for exactly one cycle → IDLE.
- Busy = 1 in SHIFT, MUL and DONE.
- Start while Busy is ignored; no queuing.
- A new Start can be accepted in the cycle after Done.

Outputs
- Out, Hi, Zero and C_out are registered.
- They update only when entering DONE and hold until the next Done.
- Zero is computed from the final Out.

## Timing
- Reset (async assert): state = IDLE; Out = 0, Hi = 0, Zero = 0, C_out = 0, Busy = 0, Done = 0.
- Reset mid-operation aborts the operation; no Done pulse is produced.
- Latency is counted from the Start-sampling edge k to the edge where Done rises:
  - single-cycle ops and shift with n = 0: k+1.
  - shift-by-N: k+1+n.
  - MUL: k+1+WIDTH.
- Operands may change freely after edge k; they are latched internally.
- Arithmetic is modulo 2^WIDTH; the add carry uses a WIDTH+1-bit sum.
- Shift amount is taken modulo WIDTH (SHW bits).

## Structure
- alu_pkg holds:
  - op_t enum with the 16 opcode names.
  - state_t enum {IDLE, SHIFT, MUL, DONE}.
  - the default WIDTH localparam.
- One combinational sub-module, alu_comb, computes all single-cycle results and flags (Out, C_out).
- alu_seq holds the FSM, operand latches, counter, shift register, and multiply accumulator.

## Test plan
All scenarios use WIDTH = 8.
1. Assert Reset_n = 0 mid-MUL → all outputs immediately 0, Busy = 0; release, then ADD 1 + 1 → Out = 0x02, Done at k+1.
2. ADD 0x80 + 0x80 → Out = 0x00, C_out = 1, Zero = 1; SUB 0x01 − 0x03 → Out = 0xFE, C_out = 1.
3. OP 7, Mode = 1, R0 = 3, Input = 0x81 → Out = 0x08, C_out = 0, Done at k+4, Busy high for 4 cycles.
4. MUL 0xFF × 0xFF → Hi = 0xFE, Out = 0x01, C_out = 1, Done at k+9; a Start pulsed at k+3 is ignored.
5. Compares: EQ 3,3 → 1; LT 3,3 → 0; GT 3,1 → 1. OP 15: R0 = 0, Input = 0xFF → Out = 0xFF; R0 = 1 → Out = 0x00, Zero = 1.
6. Back-to-back: Start held high continuously → second op accepted exactly one cycle after Done; Done never high on two consecutive cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// +------------------------------------------------------------------+
// | alu_pkg : shared opcode/state types and default width for alu_seq |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [3:0] {
    OP_PASS0 = 4'd0,
    OP_PASS1 = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_PASSA = 4'd4,
    OP_PASS5 = 4'd5,
    OP_PASS6 = 4'd6,
    OP_SHL   = 4'd7,
    OP_SHR   = 4'd8,
    OP_AND   = 4'd9,
    OP_XOR   = 4'd10,
    OP_EQ    = 4'd11,
    OP_LT    = 4'd12,
    OP_GT    = 4'd13,
    OP_MUL   = 4'd14,
    OP_ZSEL  = 4'd15
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_comb.sv
// +------------------------------------------------------------------+
// | alu_comb : single-cycle result and carry/flag for every opcode    |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [3:0]       op,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             c_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // The extra top bit of diff is the unsigned borrow.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    out   = b;
    c_out = 1'b0;
    case (op_t'(op))
      OP_ADD: begin
        out   = sum[WIDTH-1:0];
        c_out = sum[WIDTH];
      end
      OP_SUB: begin
        out   = diff[WIDTH-1:0];
        c_out = diff[WIDTH];
      end
      OP_PASSA: out = a;
      // With mode set these only reach here for a zero shift count.
      OP_SHL: begin
        if (!mode) begin
          out   = {b[WIDTH-2:0], 1'b0};
          c_out = b[WIDTH-1];
        end
      end
      OP_SHR: begin
        if (!mode) begin
          out   = {1'b0, b[WIDTH-1:1]};
          c_out = b[0];
        end
      end
      OP_AND:  out = a & b;
      OP_XOR:  out = a ^ b;
      OP_EQ:   out = WIDTH'(a == b);
      OP_LT:   out = WIDTH'(a < b);
      OP_GT:   out = WIDTH'(a > b);
      OP_MUL:  out = '0;
      OP_ZSEL: out = (a == '0) ? b : '0;
      default: out = b;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// +------------------------------------------------------------------+
// | alu_seq : multi-cycle accumulator ALU with Start/Busy/Done        |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [3:0]       OP,
  input  logic             Mode,
  input  logic [WIDTH-1:0] R0,
  input  logic [WIDTH-1:0] Input,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] Hi,
  output logic             Zero,
  output logic             C_out
);

  localparam int            CW      = SHW + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH);

  state_t           state;
  logic [CW-1:0]    count;
  logic             sh_right;
  logic [WIDTH-1:0] sh_reg;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;

  logic [WIDTH-1:0] comb_out;
  logic             comb_c;
  op_t              op_in;
  logic [SHW-1:0]   shamt;
  logic             is_mul;
  logic             is_shift_n;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op    (OP),
    .mode  (Mode),
    .a     (R0),
    .b     (Input),
    .out   (comb_out),
    .c_out (comb_c)
  );

  assign op_in      = op_t'(OP);
  assign shamt      = R0[SHW-1:0];
  assign is_mul     = (op_in == OP_MUL);
  assign is_shift_n = Mode && ((op_in == OP_SHL) || (op_in == OP_SHR)) && (shamt != '0);

  // One shift step per cycle; sh_bit is the bit leaving the register.
  logic [WIDTH-1:0] sh_next;
  logic             sh_bit;
  assign sh_next = sh_right ? {1'b0, sh_reg[WIDTH-1:1]} : {sh_reg[WIDTH-2:0], 1'b0};
  assign sh_bit  = sh_right ? sh_reg[0] : sh_reg[WIDTH-1];

  // Shift-add multiply: multiplier sits in p_lo and drains LSB-first
  // while the partial product grows down from p_hi.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;
  assign mul_sum     = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
  assign mul_hi_next = mul_sum[WIDTH:1];
  assign mul_lo_next = {mul_sum[0], p_lo[WIDTH-1:1]};

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      count    <= '0;
      sh_right <= 1'b0;
      sh_reg   <= '0;
      mcand    <= '0;
      p_hi     <= '0;
      p_lo     <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Out      <= '0;
      Hi       <= '0;
      Zero     <= 1'b0;
      C_out    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            Busy <= 1'b1;
            if (is_mul) begin
              mcand <= R0;
              p_hi  <= '0;
              p_lo  <= Input;
              count <= CNT_MUL;
              state <= MUL;
            end else if (is_shift_n) begin
              sh_reg   <= Input;
              sh_right <= (op_in == OP_SHR);
              count    <= {1'b0, shamt};
              state    <= SHIFT;
            end else begin
              Out   <= comb_out;
              Hi    <= '0;
              C_out <= comb_c;
              Zero  <= (comb_out == '0);
              state <= DONE;
            end
          end
        end
        SHIFT: begin
          sh_reg <= sh_next;
          count  <= count - CNT_ONE;
          if (count == CNT_ONE) begin
            Out   <= sh_next;
            Hi    <= '0;
            C_out <= sh_bit;
            Zero  <= (sh_next == '0);
            state <= DONE;
          end
        end
        MUL: begin
          p_hi  <= mul_hi_next;
          p_lo  <= mul_lo_next;
          count <= count - CNT_ONE;
          if (count == CNT_ONE) begin
            Out   <= mul_lo_next;
            Hi    <= mul_hi_next;
            C_out <= |mul_hi_next;
            Zero  <= (mul_lo_next == '0);
            state <= DONE;
          end
        end
        DONE: begin
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
